// File: rtl/spi_pkg.sv
// Shared state type, slave-index constants and select decoder for the SPI master.
package spi_pkg;

    localparam int unsigned SPI_WORD_W = 16;

    typedef enum logic [1:0] {IDLE, FRONT, SHIFT, BACK} spi_state_t;

    localparam logic [2:0] SS_CH1  = 3'd0;
    localparam logic [2:0] SS_CH2  = 3'd1;
    localparam logic [2:0] SS_CH3  = 3'd2;
    localparam logic [2:0] SS_TRIG = 3'd3;
    localparam logic [2:0] SS_EEP  = 3'd4;

    // Active-low one-hot select for a slave index; unknown indices select nothing.
    function automatic logic [4:0] ss_decode(input logic [2:0] idx);
        logic [4:0] sel_n;
        sel_n = '1;
        case (idx)
            SS_CH1:  sel_n = 5'b11110;
            SS_CH2:  sel_n = 5'b11101;
            SS_CH3:  sel_n = 5'b11011;
            SS_TRIG: sel_n = 5'b10111;
            SS_EEP:  sel_n = 5'b01111;
            default: sel_n = '1;
        endcase
        return sel_n;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period counter producing the registered SPI clock and edge strobes.
module spi_sclk_gen #(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic toggle_en,
    output logic sclk,
    output logic tick,
    output logic fall_en,
    output logic rise_en
);

    localparam int unsigned HALF = SCLK_DIV / 2;
    localparam int unsigned CW   = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt;

    // tick marks the edge that ends a half period; the strobes say which way SCLK moves on it.
    assign tick    = run && (cnt == LAST);
    assign fall_en = tick && toggle_en && sclk;
    assign rise_en = tick && toggle_en && !sclk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b1;
        end else begin
            if (!run || cnt == LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            if (!toggle_en)
                sclk <= 1'b1;
            else if (tick)
                sclk <= ~sclk;
        end
    end

endmodule

// File: rtl/spi_mstr.sv
// Mode-3 SPI master: one 16-bit transfer per wrt_SPI to AFE, trigger DAC or EEPROM.
// Define SPI_READBACK_EN to capture MISO and return its low byte on EEP_data.
module spi_mstr
    import spi_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wrt_SPI,
    input  logic [2:0]  ss,
    input  logic [15:0] SPI_data,
    input  logic        MISO,
    output logic        SPI_done,
    output logic [7:0]  EEP_data,
    output logic [4:0]  SS_n,
    output logic        SCLK,
    output logic        MOSI
);

    spi_state_t            state;
    logic [SPI_WORD_W-1:0] tx_sr;
    logic [4:0]            bit_cnt;
    logic                  run, toggle_en, tick, fall_en, rise_en;

    // The front porch's final tick produces the first SCLK fall, so toggling spans FRONT too.
    assign run       = (state != IDLE);
    assign toggle_en = (state == FRONT) || (state == SHIFT);

    spi_sclk_gen #(
        .SCLK_DIV(SCLK_DIV)
    ) u_sclk_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .toggle_en(toggle_en),
        .sclk     (SCLK),
        .tick     (tick),
        .fall_en  (fall_en),
        .rise_en  (rise_en)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            SS_n     <= '1;
            MOSI     <= 1'b0;
            SPI_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wrt_SPI && ss <= SS_EEP) begin
                        tx_sr    <= SPI_data;
                        SS_n     <= ss_decode(ss);
                        MOSI     <= SPI_data[SPI_WORD_W-1];
                        SPI_done <= 1'b0;
                        bit_cnt  <= '0;
                        state    <= FRONT;
                    end
                end
                FRONT: begin
                    if (tick)
                        state <= SHIFT;
                end
                SHIFT: begin
                    if (fall_en) begin
                        tx_sr <= tx_sr << 1;
                        MOSI  <= tx_sr[SPI_WORD_W-2];
                    end
                    if (rise_en) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd15)
                            state <= BACK;
                    end
                end
                BACK: begin
                    if (tick) begin
                        SS_n     <= '1;
                        SPI_done <= 1'b1;
                        MOSI     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic [SPI_WORD_W-1:0] rx_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sr    <= '0;
            EEP_data <= '0;
        end else begin
            if (state == SHIFT && rise_en)
                rx_sr <= {rx_sr[SPI_WORD_W-2:0], MISO};
            if (state == BACK && tick)
                EEP_data <= rx_sr[7:0];
        end
    end
`else
    logic unused_miso;

    assign unused_miso = MISO;
    assign EEP_data    = '0;
`endif

endmodule
